mfp_div_seq: RTL and testbench



---
 rtl/mfp_div_seq_pkg.sv | 20 ++
 rtl/mfp_div_step.sv | 21 ++
 rtl/mfp_div_seq.sv | 143 ++++++++++++++
 tb/tb_mfp_div_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_div_seq_pkg.sv
// Shared MFixPoint definitions for the sequential divider: FSM encoding and
// saturation limits for a given output width and signedness.
package mfp_div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic longint sat_max(input int unsigned w, input bit uns);
    return uns ? (longint'(1) << w) - 1 : (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned w, input bit uns);
    return uns ? longint'(0) : -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/mfp_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mfp_div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem,
  input  logic         dvd_bit,
  input  logic [W-1:0] dsr,
  output logic [W:0]   rem_next,
  output logic         qbit
);

  logic [W+1:0] part;

  always_comb begin
    part     = {rem, dvd_bit};
    qbit     = (part >= (W+2)'(dsr));
    rem_next = (W+1)'(qbit ? part - (W+2)'(dsr) : part);
  end

endmodule

// File: rtl/mfp_div_seq.sv
// Sequential restoring fixed-point divider with valid/ready handshake,
// sign application and MFixPoint-style saturation of the quotient.
module mfp_div_seq
  import mfp_div_seq_pkg::*;
#(
  parameter int In1W       = 8,
  parameter int In2W       = 8,
  parameter int OutW       = 8,
  parameter int FracShift  = 0,
  parameter int isUnsigned = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [In1W-1:0] in1,
  input  logic [In2W-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OutW-1:0] out,
  output logic            sat,
  output logic            div0
);

  localparam int ItW  = In1W + FracShift;
  localparam int CntW = $clog2(ItW + 1);
  localparam longint OMAX = sat_max(OutW, isUnsigned != 0);
  localparam longint OMIN = sat_min(OutW, isUnsigned != 0);

  state_t            state;
  logic [CntW-1:0]   cnt;
  logic [In1W-1:0]   raw1;
  logic [In2W-1:0]   raw2;
  logic [ItW-1:0]    dvd;
  logic [In2W-1:0]   dsr;
  logic [In2W:0]     rem;
  logic              div0_r;

  logic              neg1, neg2, sign;
  logic [In1W-1:0]   mag1;
  logic [In2W-1:0]   mag2;
  logic [In2W:0]     rem_next;
  logic              qbit;
  longint            qx;
  logic [OutW-1:0]   fix_out;
  logic              fix_sat;

  always_comb begin
    neg1 = (isUnsigned == 0) && raw1[In1W-1];
    neg2 = (isUnsigned == 0) && raw2[In2W-1];
    sign = neg1 ^ neg2;
    mag1 = neg1 ? -raw1 : raw1;
    mag2 = neg2 ? -raw2 : raw2;
  end

  mfp_div_step #(.W(In2W)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd[ItW-1]),
    .dsr      (dsr),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // dvd doubles as the quotient register: dividend bits shift out of the MSB
  // while quotient bits shift in at the LSB.
  always_comb begin
    qx      = sign ? -longint'(dvd) : longint'(dvd);
    fix_sat = 1'b0;
    fix_out = OutW'(qx);
    if (div0_r) begin
      fix_sat = 1'b1;
      fix_out = ((isUnsigned != 0) || !neg1) ? OutW'(OMAX) : OutW'(OMIN);
    end else if (qx > OMAX) begin
      fix_sat = 1'b1;
      fix_out = OutW'(OMAX);
    end else if (qx < OMIN) begin
      fix_sat = 1'b1;
      fix_out = OutW'(OMIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      raw1      <= '0;
      raw2      <= '0;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      div0_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      sat       <= 1'b0;
      div0      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            raw1     <= in1;
            raw2     <= in2;
            div0_r   <= (in2 == '0);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          // Operands are captured raw; magnitudes are formed in the first
          // CALC cycle, followed by ItW restoring iterations.
          if (cnt == '0) begin
            dvd <= ItW'(mag1) << FracShift;
            dsr <= mag2;
            rem <= '0;
            cnt <= cnt + 1'b1;
          end else begin
            rem <= rem_next;
            dvd <= {dvd[ItW-2:0], qbit};
            if (cnt == CntW'(ItW)) state <= FIX;
            else                   cnt   <= cnt + 1'b1;
          end
        end
        FIX: begin
          out       <= fix_out;
          sat       <= fix_sat;
          div0      <= div0_r;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_div_seq.sv
// Directed bench for mfp_div_seq: signed defaults, fractional quotient,
// unsigned mode, output back-pressure and mid-calculation reset.
module tb_mfp_div_seq;

  typedef struct {
    logic [7:0] a, b, o;
    logic       s, z;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid [3];
  logic       in_ready [3];
  logic [7:0] in1 [3];
  logic [7:0] in2 [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] outv [3];
  logic       sat [3];
  logic       div0 [3];

  int checks   = 0;
  int failures = 0;

  mfp_div_seq u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in1(in1[0]), .in2(in2[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out(outv[0]), .sat(sat[0]), .div0(div0[0])
  );

  mfp_div_seq #(.FracShift(4)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in1(in1[1]), .in2(in2[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out(outv[1]), .sat(sat[1]), .div0(div0[1])
  );

  mfp_div_seq #(.isUnsigned(1)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in1(in1[2]), .in2(in2[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out(outv[2]), .sat(sat[2]), .div0(div0[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one transaction on DUT d and returns its result and the number of
  // edges from accept to out_valid (capped at 40 if it never arrives).
  task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] o, output logic s, output logic z,
                       output int lat);
    @(negedge clk);
    in1[d] = a; in2[d] = b; in_valid[d] = 1'b1;
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    lat = 0;
    while (lat < 40 && out_valid[d] !== 1'b1) begin
      @(posedge clk);
      #1 lat++;
    end
    o = outv[d]; s = sat[d]; z = div0[d];
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1 out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || outv[d] !== 8'h00 ||
          sat[d] !== 1'b0 || div0[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut=%0d rdy=%b vld=%b out=%h sat=%b div0=%b exp rdy=1 vld=0 out=00 sat=0 div0=0",
                 d, in_ready[d], out_valid[d], outv[d], sat[d], div0[d]);
      end
    end
  endtask

  task automatic run_table(input string name, input int d, input int exp_lat, input vec_t v[$]);
    logic [7:0] o;
    logic s, z;
    int lat;
    foreach (v[i]) begin
      do_op(d, v[i].a, v[i].b, o, s, z, lat);
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL %s_lat[%0d] got=%0d exp=%0d", name, i, lat, exp_lat);
      end
      checks++;
      if (o !== v[i].o) begin
        failures++;
        $display("FAIL %s_out[%0d] %h/%h got=%h exp=%h", name, i, v[i].a, v[i].b, o, v[i].o);
      end
      checks++;
      if (s !== v[i].s || z !== v[i].z) begin
        failures++;
        $display("FAIL %s_flags[%0d] got sat=%b div0=%b exp sat=%b div0=%b", name, i, s, z, v[i].s, v[i].z);
      end
    end
  endtask

  task automatic test_signed();
    vec_t v[$];
    v = '{'{8'd100, 8'd7, 8'd14, 1'b0, 1'b0},
          '{8'h9C, 8'd7, 8'hF2, 1'b0, 1'b0},
          '{8'h80, 8'hFF, 8'h7F, 1'b1, 1'b0},
          '{8'h80, 8'h01, 8'h80, 1'b0, 1'b0},
          '{8'd5, 8'd0, 8'h7F, 1'b1, 1'b1},
          '{8'hFB, 8'd0, 8'h80, 1'b1, 1'b1},
          '{8'd0, 8'd0, 8'h7F, 1'b1, 1'b1}};
    run_table("signed", 0, 10, v);
  endtask

  task automatic test_frac();
    vec_t v[$];
    v = '{'{8'd3, 8'd2, 8'd24, 1'b0, 1'b0},
          '{8'hFF, 8'd3, 8'hFB, 1'b0, 1'b0},
          '{8'd100, 8'd1, 8'h7F, 1'b1, 1'b0},
          '{8'h9C, 8'd1, 8'h80, 1'b1, 1'b0}};
    run_table("frac", 1, 14, v);
  endtask

  task automatic test_unsigned();
    vec_t v[$];
    v = '{'{8'd255, 8'd1, 8'd255, 1'b0, 1'b0},
          '{8'd255, 8'd0, 8'd255, 1'b1, 1'b1},
          '{8'd200, 8'd3, 8'd66, 1'b0, 1'b0},
          '{8'd7, 8'd9, 8'd0, 1'b0, 1'b0}};
    run_table("unsigned", 2, 10, v);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit extra;
    @(negedge clk);
    in1[0] = 8'd60; in2[0] = 8'd4; in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    lat = 0;
    while (lat < 40 && out_valid[0] !== 1'b1) begin
      @(posedge clk);
      #1 lat++;
    end
    for (int c = 0; c < 5; c++) begin
      in1[0] = 8'd9; in2[0] = 8'd3; in_valid[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || outv[0] !== 8'd15 || in_ready[0] !== 1'b0 || sat[0] !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d] vld=%b out=%h rdy=%b sat=%b exp vld=1 out=0f rdy=0 sat=0",
                 c, out_valid[0], outv[0], in_ready[0], sat[0]);
      end
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL release vld=%b rdy=%b exp vld=0 rdy=1", out_valid[0], in_ready[0]);
    end
    extra = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      failures++;
      $display("FAIL ignored_input spurious out_valid got=1 exp=0");
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] o;
    logic s, z;
    int lat;
    bit extra;
    @(negedge clk);
    in1[0] = 8'd90; in2[0] = 8'd9; in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || outv[0] !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset rdy=%b vld=%b out=%h exp rdy=1 vld=0 out=00", in_ready[0], out_valid[0], outv[0]);
    end
    extra = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_spurious got out_valid=1 exp=0");
    end
    do_op(0, 8'd50, 8'd5, o, s, z, lat);
    checks++;
    if (o !== 8'd10 || s !== 1'b0 || z !== 1'b0 || lat !== 10) begin
      failures++;
      $display("FAIL after_reset out=%h sat=%b div0=%b lat=%0d exp out=0a sat=0 div0=0 lat=10", o, s, z, lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; in1[d] = '0; in2[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_signed();
    test_frac();
    test_unsigned();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
